// File: rtl/entropy_decode_ac_run_coefficients.sv
// rtl/entropy_decode_ac_run_coefficients.sv - bit-serial adaptive Rice/Exp-Golomb AC run decoder
// Optional ERR_CHECK_EN adds prefix/run range checking with a HALT state and dec_error_o.
module entropy_decode_ac_run_coefficients #(
  parameter int unsigned INIT_PREV_RUN = 4,
  parameter int unsigned MAX_ZEROS     = 24,
  parameter int unsigned MAX_RUN       = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        block_start_i,
  input  logic        bit_in_i,
  input  logic        bit_valid_i,
  output logic        bit_ready_o,
  output logic [31:0] run_out_o,
  output logic [31:0] codeword_length_o,
  output logic        run_valid_o,
  output logic        dec_error_o
);

`ifdef ERR_CHECK_EN
  typedef enum logic [1:0] {PREFIX, SUFFIX, EMIT, HALT} state_t;
`else
  typedef enum logic [1:0] {PREFIX, SUFFIX, EMIT} state_t;
`endif

  state_t      state_q, state_d;
  logic [5:0]  z_q, z_d;
  logic [6:0]  rem_q, rem_d;
  logic [31:0] acc_q, acc_d;
  logic        rice_q, rice_d;
  logic [7:0]  len_q, len_d;
  logic [31:0] prev_run_q, prev_run_d;
  logic [31:0] run_q, run_d;
  logic [7:0]  cw_len_q, cw_len_d;

  logic        exp_only, krice;
  logic [1:0]  kexp;
  logic [2:0]  s_off, l_thr;
  logic        is_rice, take, finish_prefix, finish_suffix, finish, rice_fin;
  logic [6:0]  n_new;
  logic [7:0]  len_new;
  logic [31:0] acc_init, acc_fin, run_fin;
  logic        err_z, err_run;

  // Codebook follows the previously decoded run.
  always_comb begin
    exp_only = 1'b0;
    krice    = 1'b0;
    kexp     = 2'd0;
    s_off    = 3'd0;
    if (prev_run_q <= 32'd1) begin
      kexp = 2'd1; s_off = 3'd3;
    end else if (prev_run_q <= 32'd3) begin
      kexp = 2'd1; s_off = 3'd2;
    end else if (prev_run_q == 32'd4) begin
      exp_only = 1'b1;
    end else if (prev_run_q <= 32'd8) begin
      krice = 1'b1; kexp = 2'd2; s_off = 3'd4;
    end else if (prev_run_q <= 32'd14) begin
      exp_only = 1'b1; kexp = 2'd1;
    end else begin
      exp_only = 1'b1; kexp = 2'd2;
    end
  end

  assign l_thr    = exp_only ? 3'd0 : (s_off >> krice);
  assign is_rice  = z_q < {3'b000, l_thr};
  assign n_new    = is_rice ? {6'd0, krice}
                            : ({1'b0, z_q} - {4'd0, l_thr} + {5'd0, kexp});
  assign len_new  = {2'b00, z_q} + 8'd1 + {1'b0, n_new};
  // Rice seeds the accumulator with q so the suffix shifts in below it.
  assign acc_init = is_rice ? {26'd0, z_q} : 32'd1;

  assign take          = bit_valid_i && bit_ready_o;
  assign finish_prefix = take && (state_q == PREFIX) && bit_in_i && (n_new == 7'd0);
  assign finish_suffix = take && (state_q == SUFFIX) && (rem_q == 7'd1);
  assign finish        = finish_prefix || finish_suffix;
  assign acc_fin       = finish_prefix ? acc_init : {acc_q[30:0], bit_in_i};
  assign rice_fin      = finish_prefix ? is_rice : rice_q;
  assign run_fin       = rice_fin ? acc_fin
                                  : acc_fin - (32'd1 << kexp) + {29'd0, s_off};

`ifdef ERR_CHECK_EN
  logic err_q;
  assign err_z       = take && (state_q == PREFIX) && !bit_in_i && (z_q == 6'(MAX_ZEROS));
  assign err_run     = finish && (run_fin > MAX_RUN);
  assign dec_error_o = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= !block_start_i && (err_z || err_run);
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^{MAX_ZEROS[0], MAX_RUN[0]};
  assign err_z       = 1'b0;
  assign err_run     = 1'b0;
  assign dec_error_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= PREFIX;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (block_start_i) state_d = PREFIX;
`ifdef ERR_CHECK_EN
    else if (err_z || err_run) state_d = HALT;
`endif
    else begin
      case (state_q)
        PREFIX:  if (finish_prefix) state_d = EMIT;
                 else if (take && bit_in_i) state_d = SUFFIX;
        SUFFIX:  if (finish_suffix) state_d = EMIT;
        EMIT:    state_d = PREFIX;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_ready_o = ((state_q == PREFIX) || (state_q == SUFFIX)) && !block_start_i;
    run_valid_o = (state_q == EMIT);
  end

  always_comb begin
    z_d        = z_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    rice_d     = rice_q;
    len_d      = len_q;
    prev_run_d = prev_run_q;
    run_d      = run_q;
    cw_len_d   = cw_len_q;
    if (block_start_i) begin
      z_d        = 6'd0;
      rem_d      = 7'd0;
      acc_d      = 32'd0;
      prev_run_d = 32'(INIT_PREV_RUN);
    end else begin
      if (state_q == EMIT) begin
        prev_run_d = run_q;
        z_d        = 6'd0;
        rem_d      = 7'd0;
        acc_d      = 32'd0;
      end
      if (take && state_q == PREFIX) begin
        if (bit_in_i) begin
          rem_d  = n_new;
          acc_d  = acc_init;
          rice_d = is_rice;
          len_d  = len_new;
        end else begin
          z_d = (z_q == 6'd63) ? z_q : z_q + 6'd1;
        end
      end
      if (take && state_q == SUFFIX) begin
        acc_d = {acc_q[30:0], bit_in_i};
        rem_d = rem_q - 7'd1;
      end
      if (finish && !err_run) begin
        run_d    = run_fin;
        cw_len_d = finish_prefix ? len_new : len_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z_q        <= 6'd0;
      rem_q      <= 7'd0;
      acc_q      <= 32'd0;
      rice_q     <= 1'b0;
      len_q      <= 8'd0;
      prev_run_q <= 32'(INIT_PREV_RUN);
      run_q      <= 32'd0;
      cw_len_q   <= 8'd0;
    end else begin
      z_q        <= z_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      rice_q     <= rice_d;
      len_q      <= len_d;
      prev_run_q <= prev_run_d;
      run_q      <= run_d;
      cw_len_q   <= cw_len_d;
    end
  end

  assign run_out_o         = run_q;
  assign codeword_length_o = {24'd0, cw_len_q};

endmodule

// File: tb/tb_entropy_decode_ac_run_coefficients.sv
// tb/tb_entropy_decode_ac_run_coefficients.sv - directed bench for the AC run decoder
module tb_entropy_decode_ac_run_coefficients;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        block_start = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic [31:0] run_out;
  logic [31:0] codeword_length;
  logic        run_valid;
  logic        dec_error;

  int n_vec = 0;
  int n_bad = 0;
  int n_derr = 0;
  logic [31:0] got_run[$];
  logic [31:0] got_len[$];

  entropy_decode_ac_run_coefficients dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .block_start_i     (block_start),
    .bit_in_i          (bit_in),
    .bit_valid_i       (bit_valid),
    .bit_ready_o       (bit_ready),
    .run_out_o         (run_out),
    .codeword_length_o (codeword_length),
    .run_valid_o       (run_valid),
    .dec_error_o       (dec_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && run_valid) begin
      got_run.push_back(run_out);
      got_len.push_back(codeword_length);
    end
    if (reset_n && dec_error) n_derr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic feed(input logic b, input int gap);
    int guard;
    guard = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bit_in = b;
    bit_valid = 1'b1;
    while (!bit_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("bit_ready_wait", 32'(bit_ready), 32'd1);
    @(posedge clk);
    #1 bit_valid = 1'b0;
  endtask

  task automatic feed_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) feed(s[i] == "1", gap);
  endtask

  task automatic pulse_bs();
    @(negedge clk);
    block_start = 1'b1;
    @(negedge clk);
    block_start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_run(input string tag, input logic [31:0] r, input logic [31:0] l);
    chk({tag, "_present"}, 32'(got_run.size() != 0), 32'd1);
    if (got_run.size() != 0) begin
      chk({tag, "_run"}, got_run.pop_front(), r);
      chk({tag, "_len"}, got_len.pop_front(), l);
    end
  endtask

  task automatic expect_none(input string tag);
    chk({tag, "_extra"}, 32'(got_run.size()), 32'd0);
    got_run.delete();
    got_len.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_run_valid", 32'(run_valid), 32'd0);
    chk("rst_run_out", run_out, 32'd0);
    chk("rst_len", codeword_length, 32'd0);
    chk("rst_dec_error", 32'(dec_error), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_bit_ready", 32'(bit_ready), 32'd1);

    // prev 4 -> 0 -> 1 -> 0 -> 3 -> 3 -> 1
    feed_str("1011", 0);
    feed_str("00010", 0);
    feed_str("0011", 0);
    feed_str("01", 0);
    settle();
    expect_run("a0", 0, 1);
    expect_run("a1", 1, 2);
    expect_run("a2", 0, 1);
    expect_run("a3", 3, 5);
    expect_run("a4", 3, 4);
    expect_run("a5", 1, 2);
    expect_none("a");

    pulse_bs();
    feed_str("010", 0);
    feed_str("00010", 0);
    settle();
    expect_run("b0", 1, 3);
    expect_run("b1", 3, 5);
    expect_none("b");

    // prev 5..8 band: Rice k1 and its Exp path, then back to exp-only k0
    pulse_bs();
    feed_str("00110", 0);
    feed_str("011", 0);
    pulse_bs();
    feed_str("00110", 0);
    feed_str("00100", 0);
    feed_str("011", 0);
    settle();
    expect_run("c0", 5, 5);
    expect_run("c1", 3, 3);
    expect_run("c2", 5, 5);
    expect_run("c3", 4, 5);
    expect_run("c4", 2, 3);
    expect_none("c");

    // exp-only k1 (prev 10) and k2 (prev 20)
    pulse_bs();
    feed_str("0001011", 0);
    feed_str("11", 0);
    pulse_bs();
    feed_str("000010101", 0);
    feed_str("111", 0);
    settle();
    expect_run("d0", 10, 7);
    expect_run("d1", 1, 2);
    expect_run("d2", 20, 9);
    expect_run("d3", 3, 3);
    expect_none("d");

    // abort a partial prefix
    pulse_bs();
    feed_str("00", 0);
    pulse_bs();
    feed_str("1", 0);
    settle();
    expect_run("e0", 0, 1);
    expect_none("e");

    // block_start during EMIT: emit completes, prev_run returns to 4
    pulse_bs();
    feed_str("00110", 0);
    block_start = 1'b1;
    chk("emit_latency_valid", 32'(run_valid), 32'd1);
    chk("emit_latency_run", run_out, 32'd5);
    @(posedge clk);
    #1 block_start = 1'b0;
    feed_str("010", 0);
    settle();
    chk("hold_run_out", run_out, 32'd1);
    chk("hold_len", codeword_length, 32'd3);
    expect_run("f0", 5, 5);
    expect_run("f1", 1, 3);
    expect_none("f");

    // bit_valid gaps mid-codeword
    pulse_bs();
    feed_str("00110", 2);
    feed_str("011", 3);
    settle();
    expect_run("g0", 5, 5);
    expect_run("g1", 3, 3);
    expect_none("g");

`ifdef ERR_CHECK_EN
    pulse_bs();
    for (int i = 0; i < 25; i++) feed(1'b0, 0);
    chk("err_pulse", 32'(dec_error), 32'd1);
    chk("err_halt_ready", 32'(bit_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("err_pulse_end", 32'(dec_error), 32'd0);
    chk("err_halt_ready_hold", 32'(bit_ready), 32'd0);
    expect_none("h_err");
    pulse_bs();
    feed_str("1", 0);
    settle();
    expect_run("h0", 0, 1);
    expect_none("h");
    chk("dec_error_count", 32'(n_derr), 32'd1);
`else
    chk("dec_error_count", 32'(n_derr), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
